pico_rx_engine: RTL



---
 rtl/pico_pkg.sv | 17 +
 rtl/pico_sync_edge.sv | 43 ++++
 rtl/pico_rx_engine.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pico_pkg.sv
// Shared types and default parameter values for the pico SPI receive engine.
//   state_t          : receive FSM states (idle, header word, data words)
//   *_DEF constants  : default values for the engine's parameters
package pico_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA
    } state_t;

    localparam int unsigned WORD_W_DEF      = 8;
    localparam int unsigned ADDR_W_DEF      = 7;
    localparam int unsigned TIMEOUT_DEF     = 4;
    localparam int unsigned SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/pico_sync_edge.sv
// Multi-flop synchroniser for the asynchronous SPI clock and data lines,
// plus rising-edge detection on the synchronised SPI clock.
//   iclk, rst  : internal clock, asynchronous active-high reset
//   sclk       : raw SPI clock
//   serial_in  : raw SPI data
//   sclk_sync  : SPI clock after SYNC_STAGES flops
//   data_sync  : SPI data after SYNC_STAGES flops (same depth as sclk_sync)
//   rise       : sclk_sync is 1 and was 0 on the previous iclk cycle
module pico_sync_edge
    import pico_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic iclk,
    input  logic rst,
    input  logic sclk,
    input  logic serial_in,
    output logic sclk_sync,
    output logic data_sync,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sclk_sr;
    logic [SYNC_STAGES-1:0] data_sr;
    logic                   sclk_prev;

    always_ff @(posedge iclk or posedge rst) begin
        if (rst) begin
            sclk_sr   <= '0;
            data_sr   <= '0;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], sclk};
            data_sr   <= {data_sr[SYNC_STAGES-2:0], serial_in};
            sclk_prev <= sclk_sr[SYNC_STAGES-1];
        end
    end

    assign sclk_sync = sclk_sr[SYNC_STAGES-1];
    assign data_sync = data_sr[SYNC_STAGES-1];
    assign rise      = sclk_sync & ~sclk_prev;

endmodule

// File: rtl/pico_rx_engine.sv
// SPI-style receive engine: oversamples sclk/serial_in on iclk, assembles
// MSB-first words, decodes a header word (bit WORD_W-1 = read flag, low
// ADDR_W bits = start address) and then either emits one write strobe per
// data word or just advances the address for read frames. A frame ends when
// sclk stays low for TIMEOUT iclk cycles; ending mid-word flags frame_err.
//   iclk, rst     : internal clock, asynchronous active-high reset
//   sclk          : SPI clock (asynchronous, sampled as data)
//   serial_in     : SPI data, valid at sclk rise
//   wr_en         : one-cycle write strobe
//   wr_data       : written word, held after the strobe
//   addr          : register pointer
//   rd_mode       : current/last frame is a read frame
//   frame_active  : FSM is not idle
//   frame_err     : sticky, last frame ended with a partial word
module pico_rx_engine
    import pico_pkg::*;
#(
    parameter int unsigned WORD_W      = WORD_W_DEF,
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned TIMEOUT     = TIMEOUT_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              iclk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              serial_in,
    output logic              wr_en,
    output logic [WORD_W-1:0] wr_data,
    output logic [ADDR_W-1:0] addr,
    output logic              rd_mode,
    output logic              frame_active,
    output logic              frame_err
);

    localparam int unsigned        CNT_W    = $clog2(WORD_W);
    localparam int unsigned        IDLE_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WORD_W - 1);
    localparam logic [IDLE_W-1:0]  IDLE_MAX = IDLE_W'(TIMEOUT);

    state_t              state;
    state_t              state_next;
    logic                sclk_sync;
    logic                data_sync;
    logic                rise;
    logic [CNT_W-1:0]    bit_cnt;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [IDLE_W-1:0]   idle_next;
    // Only the WORD_W-1 most recent bits need storing; the incoming bit
    // completes the word combinationally in word_next.
    logic [WORD_W-2:0]   shreg;
    logic [WORD_W-1:0]   word_next;
    logic                word_done;
    logic                timeout;

    pico_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .iclk      (iclk),
        .rst       (rst),
        .sclk      (sclk),
        .serial_in (serial_in),
        .sclk_sync (sclk_sync),
        .data_sync (data_sync),
        .rise      (rise)
    );

    // Timeout is judged on the counter's next value, so a rise (which forces
    // the counter to 0) can never coincide with a timeout.
    always_comb begin
        word_next  = {shreg, data_sync};
        word_done  = rise && (bit_cnt == LAST_BIT);
        if (sclk_sync) begin
            idle_next = '0;
        end else if (idle_cnt == IDLE_MAX) begin
            idle_next = idle_cnt;
        end else begin
            idle_next = idle_cnt + 1'b1;
        end
        timeout    = (state != ST_IDLE) && (idle_next == IDLE_MAX);

        state_next = state;
        case (state)
            ST_IDLE:   if (rise) state_next = ST_HEADER;
            ST_HEADER: begin
                if (timeout)        state_next = ST_IDLE;
                else if (word_done) state_next = ST_DATA;
            end
            ST_DATA:   if (timeout) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge iclk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge iclk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= '0;
            idle_cnt  <= '0;
            shreg     <= '0;
            wr_en     <= 1'b0;
            wr_data   <= '0;
            addr      <= '0;
            rd_mode   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            idle_cnt <= idle_next;
            wr_en    <= 1'b0;
            // Write frames advance the pointer the cycle after the strobe.
            if (wr_en) begin
                addr <= addr + 1'b1;
            end

            if (timeout) begin
                bit_cnt <= '0;
                shreg   <= '0;
                if (bit_cnt != '0) begin
                    frame_err <= 1'b1;
                end
            end else if (rise) begin
                shreg   <= word_next[WORD_W-2:0];
                bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
                if (state == ST_IDLE) begin
                    frame_err <= 1'b0;
                end
                if (word_done) begin
                    if (state == ST_HEADER) begin
                        addr    <= word_next[ADDR_W-1:0];
                        rd_mode <= word_next[WORD_W-1];
                    end else if (state == ST_DATA) begin
                        if (rd_mode) begin
                            addr <= addr + 1'b1;
                        end else begin
                            wr_data <= word_next;
                            wr_en   <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign frame_active = (state != ST_IDLE);

endmodule
